// File: rtl/rs255_239_serial_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rs255_239_serial_encoder
// Description : Systematic RS(255,239) encoder over GF(2^8), one symbol per
//               cycle. Message passes through, then 16 parity symbols follow.
// Revision    : 1.0  initial release
// ============================================================================
module rs255_239_serial_encoder #(
    // Generator coefficients g15..g0, g15 in the most significant byte.
    parameter logic [127:0] G = 128'h3b0d68bd44d11e08a34129e56232243b
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_sof,
    output logic       m_eof,
    output logic       m_par
);

    localparam logic [0:0] S_DATA      = 1'b0;
    localparam logic [0:0] S_PARITY    = 1'b1;
    localparam logic [7:0] c_LAST_DATA = 8'd238;
    localparam logic [3:0] c_LAST_PAR  = 4'd15;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [7:0] r_cnt;
    logic [3:0] r_pcnt;
    logic [7:0] r_lfsr [16];
    logic [7:0] w_prod [16];
    logic [7:0] w_fb;
    logic       w_accept;

    // Multiply by a constant over GF(2^8) mod 0x11D; reduces to an XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
        end
        return p;
    endfunction

    assign w_fb = s_data ^ r_lfsr[15];

    for (genvar i = 0; i < 16; i++) begin : g_tap
        assign w_prod[i] = gf_mul(w_fb, G[8*i +: 8]);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_DATA;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_DATA) begin
            if (w_accept && (r_cnt == c_LAST_DATA)) w_state_nxt = S_PARITY;
        end else begin
            if (r_pcnt == c_LAST_PAR) w_state_nxt = S_DATA;
        end
    end

    // Output logic
    always_comb begin
        s_ready  = (r_state == S_DATA);
        w_accept = s_valid && (r_state == S_DATA);
    end

    // LFSR, counters and registered output stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 8'd0;
            r_pcnt  <= 4'd0;
            for (int i = 0; i < 16; i++) r_lfsr[i] <= 8'h00;
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_sof   <= 1'b0;
            m_eof   <= 1'b0;
            m_par   <= 1'b0;
        end else if (r_state == S_DATA) begin
            if (w_accept) begin
                r_lfsr[0] <= w_prod[0];
                for (int i = 1; i < 16; i++) r_lfsr[i] <= r_lfsr[i-1] ^ w_prod[i];
                m_valid <= 1'b1;
                m_data  <= s_data;
                m_sof   <= (r_cnt == 8'd0);
                m_eof   <= 1'b0;
                m_par   <= 1'b0;
                r_cnt   <= (r_cnt == c_LAST_DATA) ? 8'd0 : r_cnt + 8'd1;
            end else begin
                m_valid <= 1'b0;
                m_sof   <= 1'b0;
                m_eof   <= 1'b0;
                m_par   <= 1'b0;
            end
        end else begin
            // Drain the remainder, highest degree first; zero fill leaves it clear.
            r_lfsr[0] <= 8'h00;
            for (int i = 1; i < 16; i++) r_lfsr[i] <= r_lfsr[i-1];
            m_valid <= 1'b1;
            m_data  <= r_lfsr[15];
            m_sof   <= 1'b0;
            m_eof   <= (r_pcnt == c_LAST_PAR);
            m_par   <= 1'b1;
            r_pcnt  <= (r_pcnt == c_LAST_PAR) ? 4'd0 : r_pcnt + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs255_239_serial_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs255_239_serial_encoder
// Description : Directed self-checking bench for the RS(255,239) encoder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rs255_239_serial_encoder;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_eof;
    logic       m_par;

    rs255_239_serial_encoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_sof   (m_sof),
        .m_eof   (m_eof),
        .m_par   (m_par)
    );

    // Unit-vector message parity is g(x) minus its leading term: g15..g0.
    localparam logic [7:0] UNIT_PAR [16] = '{8'h3b, 8'h0d, 8'h68, 8'hbd, 8'h44, 8'hd1, 8'h1e, 8'h08,
                                             8'ha3, 8'h41, 8'h29, 8'he5, 8'h62, 8'h32, 8'h24, 8'h3b};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] msgs [2][239];
    logic [7:0] cap_data [$];
    bit         cap_sof  [$];
    bit         cap_eof  [$];
    bit         cap_par  [$];
    int         cap_cyc  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_valid === 1'b1) begin
            cap_data.push_back(m_data);
            cap_sof.push_back(m_sof);
            cap_eof.push_back(m_eof);
            cap_par.push_back(m_par);
            cap_cyc.push_back(cyc);
        end
    end

    function automatic logic [7:0] gfm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p ^= aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1d) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_cap();
        cap_data.delete(); cap_sof.delete(); cap_eof.delete();
        cap_par.delete();  cap_cyc.delete();
    endtask

    task automatic reset_checks(input string tag);
        #1;
        chk({tag, "_outs"}, {23'd0, m_valid, m_data, m_sof, m_eof, m_par}, 32'd0);
        chk({tag, "_ready"}, {31'd0, s_ready}, 32'd1);
    endtask

    // Feeds message idx; optionally asserts reset once abort_at symbols were accepted.
    task automatic send_frame(input string tag, input int idx, input bit gapped, input int abort_at);
        int  acc_n = 0;
        int  guard = 0;
        int  gap_err = 0;
        bit  first = 1'b1;
        bit  prev_acc = 1'b0;
        while (acc_n < 239 && guard < 3000) begin
            if (acc_n == abort_at) begin
                rst_n   = 1'b0;
                s_valid = 1'b0;
                return;
            end
            if (!first && (m_valid !== prev_acc)) gap_err++;
            s_valid  = gapped ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data   = msgs[idx][acc_n];
            prev_acc = s_valid && s_ready;
            step();
            if (prev_acc) acc_n++;
            first = 1'b0;
            guard++;
        end
        if (m_valid !== prev_acc) gap_err++;
        chk({tag, "_accepted"}, acc_n, 239);
        chk({tag, "_valid_gaps"}, gap_err, 0);
    endtask

    // Runs through the parity phase until m_eof is seen (or aborts after abort_par parity symbols).
    task automatic wait_eof(input string tag, input bit gapped, input int abort_par);
        int low = 0;
        int npar = 0;
        bit done = 1'b0;
        for (int g = 0; g < 40; g++) begin
            if (m_valid === 1'b1 && m_par === 1'b1) npar++;
            if (npar == abort_par) begin
                rst_n   = 1'b0;
                s_valid = 1'b0;
                return;
            end
            if (m_eof === 1'b1) begin
                done = 1'b1;
                break;
            end
            s_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b0;
            s_data  = 8'($urandom);
            if (s_ready === 1'b0) low++;
            step();
        end
        s_valid = 1'b0;
        chk({tag, "_eof_seen"}, {31'd0, done}, 32'd1);
        chk({tag, "_ready_low"}, low, 16);
    endtask

    // mode 0: parity all zero, 1: unit-vector parity, 2: syndromes only.
    task automatic check_frame(input string tag, input int base, input int idx, input int mode);
        int derr = 0;
        int ferr = 0;
        int perr = 0;
        int serr = 0;
        logic [7:0] a = 8'h01;
        logic [7:0] s;
        if (cap_data.size() < base + 255) begin
            chk({tag, "_count"}, cap_data.size(), base + 255);
            return;
        end
        for (int j = 0; j < 239; j++) if (cap_data[base+j] !== msgs[idx][j]) derr++;
        for (int j = 0; j < 255; j++) begin
            if (cap_sof[base+j] != (j == 0))   ferr++;
            if (cap_eof[base+j] != (j == 254)) ferr++;
            if (cap_par[base+j] != (j >= 239)) ferr++;
        end
        for (int j = 0; j < 16; j++) begin
            if (mode == 0 && cap_data[base+239+j] !== 8'h00)       perr++;
            if (mode == 1 && cap_data[base+239+j] !== UNIT_PAR[j]) perr++;
        end
        for (int i = 0; i < 16; i++) begin
            s = 8'h00;
            for (int j = 0; j < 255; j++) s = gfm(s, a) ^ cap_data[base+j];
            if (s != 8'h00) serr++;
            a = gfm(a, 8'h02);
        end
        chk({tag, "_data"}, derr, 0);
        chk({tag, "_flags"}, ferr, 0);
        if (mode != 2) chk({tag, "_parity"}, perr, 0);
        chk({tag, "_syndromes"}, serr, 0);
    endtask

    task automatic load_unit(input int idx);
        for (int j = 0; j < 239; j++) msgs[idx][j] = 8'h00;
        msgs[idx][238] = 8'h01;
    endtask

    task automatic abort_aftermath(input string tag);
        reset_checks(tag);
        clear_cap();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk({tag, "_no_outputs"}, cap_data.size(), 0);
        load_unit(0);
        send_frame({tag, "_next"}, 0, 1'b0, -1);
        wait_eof({tag, "_next"}, 1'b0, -1);
        check_frame({tag, "_next"}, 0, 0, 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        step();
        step();
        reset_checks("reset");
        rst_n = 1'b1;
        step();

        // All-zero message
        for (int j = 0; j < 239; j++) msgs[0][j] = 8'h00;
        clear_cap();
        send_frame("zero", 0, 1'b0, -1);
        wait_eof("zero", 1'b0, -1);
        check_frame("zero", 0, 0, 0);

        // Unit vector, continuous and gapped
        load_unit(0);
        clear_cap();
        send_frame("unit", 0, 1'b0, -1);
        wait_eof("unit", 1'b0, -1);
        check_frame("unit", 0, 0, 1);

        clear_cap();
        send_frame("gap", 0, 1'b1, -1);
        wait_eof("gap", 1'b1, -1);
        check_frame("gap", 0, 0, 1);

        // Back-to-back random frames
        for (int j = 0; j < 239; j++) begin
            msgs[0][j] = 8'($urandom);
            msgs[1][j] = 8'($urandom);
        end
        clear_cap();
        send_frame("b2b_a", 0, 1'b0, -1);
        wait_eof("b2b_a", 1'b0, -1);
        send_frame("b2b_b", 1, 1'b0, -1);
        wait_eof("b2b_b", 1'b0, -1);
        check_frame("b2b_a", 0, 0, 2);
        check_frame("b2b_b", 255, 1, 2);
        if (cap_cyc.size() >= 256)
            chk("b2b_adjacent", cap_cyc[255] - cap_cyc[254], 1);
        else
            chk("b2b_adjacent_count", cap_cyc.size(), 510);

        // Reset at data symbol 100
        for (int j = 0; j < 239; j++) msgs[0][j] = 8'($urandom);
        clear_cap();
        send_frame("rst_data", 0, 1'b0, 100);
        abort_aftermath("rst_data");

        // Reset at parity symbol 5
        for (int j = 0; j < 239; j++) msgs[0][j] = 8'($urandom);
        clear_cap();
        send_frame("rst_par", 0, 1'b0, -1);
        wait_eof("rst_par", 1'b0, 5);
        abort_aftermath("rst_par");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
